// File: rtl/key_event_if.sv
// Key event stream: valid/ready handshake carrying one key code per transfer.
interface key_event_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_code;
    logic       evt_repeat;

    modport master (output evt_valid, output evt_code, output evt_repeat, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_repeat, output evt_ready);
endinterface

// File: rtl/key_event_ctrl.sv
// Key event controller: press-edge detection, single-key auto-repeat tracker,
// per-key pending bits and a round-robin arbiter feeding a valid/ready output.
module key_event_ctrl #(
    parameter int TICK_CNT     = 999_999,
    parameter int REPEAT_DELAY = 25,
    parameter int REPEAT_RATE  = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] key_lvl,
    key_event_if.master evt,
    output logic        drop_err
);
    localparam int NUM_KEYS = 16;
    localparam int TW       = (TICK_CNT > 0) ? $clog2(TICK_CNT + 1) : 1;
    localparam int HMAX     = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW       = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

    typedef enum logic [1:0] {T_IDLE, T_DELAY, T_RATE} trk_st_e;

    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                tick;
    logic [NUM_KEYS-1:0] key_prev_q, press;
    trk_st_e             trk_st_q, trk_st_d;
    logic [3:0]          trk_idx_q, trk_idx_d, low_idx;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d, hold_inc;
    logic                fire;
    logic [NUM_KEYS-1:0] pend_q, pend_d, rep_q, rep_d, set_v, gnt_v;
    logic [3:0]          ptr_q, ptr_d, gnt_idx, cand;
    logic                gnt_any, load;
    logic                valid_q, valid_d, repeat_q, repeat_d, drop_q, drop_d;
    logic [3:0]          code_q, code_d;

    // Free-running tick divider and key edge detection
    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_CNT));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        press      = key_lvl & ~key_prev_q;
    end

    // Hold tracker next state: a new press retargets, release idles, ticks advance
    always_comb begin
        trk_st_d   = trk_st_q;
        trk_idx_d  = trk_idx_q;
        hold_cnt_d = hold_cnt_q;
        hold_inc   = hold_cnt_q + 1'b1;
        fire       = 1'b0;
        low_idx    = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (key_lvl[i]) low_idx = 4'(i);
        if (|press) begin
            trk_st_d   = T_DELAY;
            trk_idx_d  = low_idx;
            hold_cnt_d = '0;
        end else if (trk_st_q != T_IDLE) begin
            if (!key_lvl[trk_idx_q]) begin
                trk_st_d = T_IDLE;
            end else if (tick) begin
                hold_cnt_d = hold_inc;
                if (trk_st_q == T_DELAY && hold_inc == HW'(REPEAT_DELAY)) begin
                    fire       = 1'b1;
                    hold_cnt_d = '0;
                    trk_st_d   = T_RATE;
                end else if (trk_st_q == T_RATE && hold_inc == HW'(REPEAT_RATE)) begin
                    fire       = 1'b1;
                    hold_cnt_d = '0;
                end
            end
        end
    end

    // Round-robin pick, pending-bit update and output register next state
    always_comb begin
        set_v   = press | (fire ? (16'(1) << trk_idx_q) : '0);
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_KEYS; k++) begin
            cand = ptr_q + 4'(k);
            if (!gnt_any && pend_q[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        load  = gnt_any && (!valid_q || evt.evt_ready);
        gnt_v = load ? (16'(1) << gnt_idx) : '0;

        // A set on a bit granted this cycle keeps the new event pending
        pend_d = (pend_q & ~gnt_v) | set_v;
        rep_d  = rep_q;
        for (int i = 0; i < NUM_KEYS; i++)
            if (set_v[i]) rep_d[i] = ~press[i];
        drop_d = drop_q | (|(set_v & pend_q & ~gnt_v));

        valid_d  = valid_q;
        code_d   = code_q;
        repeat_d = repeat_q;
        ptr_d    = ptr_q;
        if (load) begin
            valid_d  = 1'b1;
            code_d   = gnt_idx;
            repeat_d = rep_q[gnt_idx];
            ptr_d    = gnt_idx;
        end else if (valid_q && evt.evt_ready) begin
            valid_d  = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt_q <= '0;
            key_prev_q <= '0;
            trk_st_q   <= T_IDLE;
            trk_idx_q  <= '0;
            hold_cnt_q <= '0;
            pend_q     <= '0;
            rep_q      <= '0;
            ptr_q      <= 4'hF;
            valid_q    <= 1'b0;
            code_q     <= '0;
            repeat_q   <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            key_prev_q <= key_lvl;
            trk_st_q   <= trk_st_d;
            trk_idx_q  <= trk_idx_d;
            hold_cnt_q <= hold_cnt_d;
            pend_q     <= pend_d;
            rep_q      <= rep_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            repeat_q   <= repeat_d;
            drop_q     <= drop_d;
        end
    end

    assign evt.evt_valid  = valid_q;
    assign evt.evt_code   = code_q;
    assign evt.evt_repeat = repeat_q;
    assign drop_err       = drop_q;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a timestamped expected-event scoreboard.
module tb_key_event_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] key_lvl;
    logic        drop_err;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    typedef struct {
        logic [3:0] code;
        logic       rep;
        int         t;
    } exp_t;
    exp_t sb[$];

    key_event_if ev();

    key_event_ctrl #(.TICK_CNT(9), .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .key_lvl  (key_lvl),
        .evt      (ev),
        .drop_err (drop_err)
    );

    always #5 clk = ~clk;

    // Edges since reset release; tick edges are multiples of 10
    always @(posedge clk or negedge rstn)
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] code, input logic rep, input int t);
        exp_t e;
        e.code = code; e.rep = rep; e.t = t;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    // Compare every accepted event against the head of the scoreboard
    always @(negedge clk) begin
        if (rstn && ev.evt_valid && ev.evt_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_evt: got code %0h rep %0b want none (cyc %0d)",
                       ev.evt_code, ev.evt_repeat, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("evt_code", 32'(ev.evt_code), 32'(e.code));
                check("evt_repeat", 32'(ev.evt_repeat), 32'(e.rep));
                check("evt_time", cyc, e.t);
            end
        end
    end

    initial begin
        int c, n, t1;
        rstn = 1'b0;
        key_lvl = '0;
        ev.evt_ready = 1'b1;
        step();
        check("rst_valid", 32'(ev.evt_valid), 0);
        check("rst_code", 32'(ev.evt_code), 0);
        check("rst_repeat", 32'(ev.evt_repeat), 0);
        check("rst_drop", 32'(drop_err), 0);
        step();
        rstn = 1'b1;

        // 1: idle keys produce nothing
        for (int i = 0; i < 100; i++) begin
            step();
            check("idle_valid", 32'(ev.evt_valid), 0);
            check("idle_drop", 32'(drop_err), 0);
        end

        // 2: single press of key 5, event two edges after the level rises
        key_lvl = 16'h0020;
        c = cyc;
        push(4'd5, 1'b0, c + 2);
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 3) check("single_one_clk", 32'(ev.evt_valid), 0);
        end
        key_lvl = '0;
        repeat (5) step();

        // 3: simultaneous presses from ptr=15, then wrap back to key 0
        do_reset();
        step();
        key_lvl = 16'h8101;
        c = cyc;
        push(4'd0, 1'b0, c + 2);
        push(4'd8, 1'b0, c + 3);
        push(4'd15, 1'b0, c + 4);
        repeat (5) step();
        key_lvl = '0;
        repeat (3) step();
        key_lvl = 16'h0001;
        push(4'd0, 1'b0, cyc + 2);
        repeat (3) step();
        key_lvl = '0;
        repeat (3) step();

        // 4: hold key 3 for 100 clk: press, then repeats at tick 3, 5, 7, 9
        step();
        key_lvl = 16'h0008;
        c  = cyc;
        n  = c + 1;
        t1 = (n / 10 + 1) * 10;
        push(4'd3, 1'b0, c + 2);
        for (int r = 0; r < 4; r++) push(4'd3, 1'b1, t1 + 21 + 20 * r);
        repeat (100) step();
        key_lvl = '0;
        repeat (40) step();
        check("hold_sb_empty", 32'(sb.size()), 0);

        // 5: stalled consumer: hold code 2, queue 9, re-press 2, then merge a second re-press
        ev.evt_ready = 1'b0;
        key_lvl = 16'h0004;
        step(); key_lvl = '0;
        step(); key_lvl = 16'h0200;
        check("stall_valid", 32'(ev.evt_valid), 1);
        check("stall_code", 32'(ev.evt_code), 2);
        step(); key_lvl = '0;
        check("stall_code_hold", 32'(ev.evt_code), 2);
        step(); key_lvl = 16'h0004;
        step(); key_lvl = '0;
        check("no_drop_yet", 32'(drop_err), 0);
        check("stall_code_hold2", 32'(ev.evt_code), 2);
        step(); key_lvl = 16'h0004;
        step(); key_lvl = '0;
        check("drop_set", 32'(drop_err), 1);
        check("stall_valid2", 32'(ev.evt_valid), 1);
        check("stall_code_hold3", 32'(ev.evt_code), 2);
        step();
        c = cyc;
        push(4'd2, 1'b0, c);
        push(4'd9, 1'b0, c + 1);
        push(4'd2, 1'b0, c + 2);
        ev.evt_ready = 1'b1;
        repeat (5) step();
        check("drop_sticky", 32'(drop_err), 1);
        check("stall_sb_empty", 32'(sb.size()), 0);

        // 6: asynchronous reset while an event is held discards it
        ev.evt_ready = 1'b0;
        key_lvl = 16'h0010;
        repeat (4) step();
        check("pre_rst_valid", 32'(ev.evt_valid), 1);
        check("pre_rst_code", 32'(ev.evt_code), 4);
        #2;
        rstn = 1'b0;
        key_lvl = '0;
        #1;
        check("async_rst_valid", 32'(ev.evt_valid), 0);
        check("async_rst_drop", 32'(drop_err), 0);
        check("async_rst_code", 32'(ev.evt_code), 0);
        step();
        step();
        rstn = 1'b1;
        ev.evt_ready = 1'b1;
        repeat (50) step();
        check("post_rst_valid", 32'(ev.evt_valid), 0);
        check("final_sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
